// File: rtl/count_pkg.sv
// Shared types for the programmable mod-N counter: mode encoding and default widths.
package count_pkg;

  typedef enum logic [1:0] {
    WRAP    = 2'd0,
    SAT     = 2'd1,
    ONESHOT = 2'd2,
    RSVD    = 2'd3
  } count_mode_t;

  localparam int COUNT_W_DEFAULT = 20;
  localparam int PRE_W_DEFAULT   = 8;

endpackage

// File: rtl/count_mod_n_if.sv
// Control/status bundle between a host and count_mod_n; the host drives controls, the counter returns status.
interface count_mod_n_if #(
  parameter int W     = 20,
  parameter int PRE_W = 8
);

  logic             en;
  logic             up;
  logic             load;
  logic [W-1:0]     load_val;
  logic [W-1:0]     max_val;
  logic [1:0]       mode;
  logic [PRE_W-1:0] presc;
  logic [W-1:0]     count;
  logic             tc;
  logic             done;

  modport master (
    output en, up, load, load_val, max_val, mode, presc,
    input  count, tc, done
  );

  modport slave (
    input  en, up, load, load_val, max_val, mode, presc,
    output count, tc, done
  );

endinterface

// File: rtl/count_mod_n_prescaler.sv
// Prescaler: emits a one-cycle strobe every presc+1 enabled cycles; clr restarts the divide.
module prescaler #(
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [PRE_W-1:0] presc,
  output logic             strobe
);

  logic [PRE_W-1:0] p;

  // p beyond presc (after a runtime shrink) is treated as having reached it
  assign strobe = en && (p >= presc);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      p <= '0;
    end else if (en) begin
      if (p >= presc) begin
        p <= '0;
      end else begin
        p <= p + PRE_W'(1);
      end
    end
  end

endmodule

// File: rtl/count_mod_n.sv
// Programmable up/down mod-N counter with wrap, saturate and one-shot modes plus registered tc/done.
module count_mod_n #(
  parameter int W     = 20,
  parameter int PRE_W = 8
) (
  input logic         clk,
  input logic         rst,
  count_mod_n_if.slave bus
);

  import count_pkg::*;

  count_mode_t  mode_q;
  logic         strobe;
  logic         is_wrap;
  logic         is_oneshot;
  logic         step;
  logic         hit;
  logic [W-1:0] term;
  logic [W-1:0] count_next;
  logic [W-1:0] load_clamped;
  logic [W-1:0] count_r;
  logic         tc_r;
  logic         done_r;

  prescaler #(.PRE_W(PRE_W)) u_presc (
    .clk    (clk),
    .rst    (rst),
    .clr    (bus.load),
    .en     (bus.en),
    .presc  (bus.presc),
    .strobe (strobe)
  );

  assign mode_q = count_mode_t'(bus.mode);

  // Reserved mode falls back to wrap; a finished one-shot ignores further strobes
  always_comb begin
    is_wrap      = (mode_q == WRAP) || (mode_q == RSVD);
    is_oneshot   = (mode_q == ONESHOT);
    step         = strobe && !bus.load && !(is_oneshot && done_r);
    term         = bus.up ? bus.max_val : '0;
    load_clamped = (bus.load_val > bus.max_val) ? bus.max_val : bus.load_val;
    count_next   = count_r;
    if (bus.up) begin
      if (count_r < bus.max_val) begin
        count_next = count_r + W'(1);
      end else begin
        count_next = is_wrap ? '0 : bus.max_val;
      end
    end else begin
      if (count_r == '0) begin
        count_next = is_wrap ? bus.max_val : '0;
      end else if (count_r > bus.max_val) begin
        count_next = bus.max_val;
      end else begin
        count_next = count_r - W'(1);
      end
    end
    // Sitting at the terminal only re-pulses in wrap mode
    hit = (count_next == term) && (is_wrap || (count_r != term));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
      tc_r    <= 1'b0;
      done_r  <= 1'b0;
    end else if (bus.load) begin
      count_r <= load_clamped;
      tc_r    <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      if (step) begin
        count_r <= count_next;
      end
      tc_r <= step && hit;
      if (step && hit && is_oneshot) begin
        done_r <= 1'b1;
      end
    end
  end

  assign bus.count = count_r;
  assign bus.tc    = tc_r;
  assign bus.done  = done_r;

endmodule

// File: tb/tb_count_mod_n.sv
// Directed bench for count_mod_n: hand-computed count/tc/done after each clock.
module tb_count_mod_n;

  import count_pkg::*;

  localparam int W     = 20;
  localparam int PRE_W = 8;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  count_mod_n_if #(.W(W), .PRE_W(PRE_W)) bus ();

  count_mod_n #(.W(W), .PRE_W(PRE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic en, input logic up,
                               input logic load, input int load_val, input int max_val,
                               input logic [1:0] mode, input int presc);
    rst          = r;
    bus.en       = en;
    bus.up       = up;
    bus.load     = load;
    bus.load_val = load_val[W-1:0];
    bus.max_val  = max_val[W-1:0];
    bus.mode     = mode;
    bus.presc    = presc[PRE_W-1:0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int exp_count,
                             input logic exp_tc, input logic exp_done);
    logic [W-1:0] ec;
    ec = exp_count[W-1:0];
    checks++;
    assert (bus.count === ec) else begin
      errors++;
      $error("[TB] FAIL %s count: got %0d expected %0d", tag, bus.count, ec);
    end
    checks++;
    assert (bus.tc === exp_tc) else begin
      errors++;
      $error("[TB] FAIL %s tc: got %b expected %b", tag, bus.tc, exp_tc);
    end
    checks++;
    assert (bus.done === exp_done) else begin
      errors++;
      $error("[TB] FAIL %s done: got %b expected %b", tag, bus.done, exp_done);
    end
  endtask

  int   wrap_c[5] = '{1, 2, 3, 0, 1};
  logic wrap_t[5] = '{0, 0, 1, 0, 0};
  int   sat_c[7]  = '{2, 1, 1, 0, 0, 0, 0};
  logic sat_t[7]  = '{0, 0, 0, 1, 0, 0, 0};
  int   one_c[7]  = '{1, 2, 3, 4, 5, 5, 5};
  logic one_t[7]  = '{0, 0, 0, 0, 1, 0, 0};
  logic one_d[7]  = '{0, 0, 0, 0, 1, 1, 1};

  initial begin
    errors = 0;
    checks = 0;

    $display("[TB] reset");
    applyStimulus(1, 0, 1, 0, 0, 3, WRAP, 0);
    tick();
    checkOutput("reset", 0, 0, 0);

    $display("[TB] wrap up, max 3");
    applyStimulus(0, 1, 1, 0, 0, 3, WRAP, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("wrap_up", wrap_c[i], wrap_t[i], 0);
    end

    $display("[TB] sat down, presc 1");
    applyStimulus(0, 1, 0, 1, 2, 3, SAT, 1);
    tick();
    checkOutput("sat_load", 2, 0, 0);
    applyStimulus(0, 1, 0, 0, 2, 3, SAT, 1);
    for (int i = 0; i < 7; i++) begin
      tick();
      checkOutput("sat_down", sat_c[i], sat_t[i], 0);
    end

    $display("[TB] oneshot up, max 5");
    applyStimulus(0, 1, 1, 1, 0, 5, ONESHOT, 0);
    tick();
    checkOutput("one_load", 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 5, ONESHOT, 0);
    for (int i = 0; i < 7; i++) begin
      tick();
      checkOutput("one_up", one_c[i], one_t[i], one_d[i]);
    end
    applyStimulus(0, 1, 1, 1, 9, 5, ONESHOT, 0);
    tick();
    checkOutput("one_reload_clamp", 5, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 5, ONESHOT, 0);
    tick();
    checkOutput("one_hold_no_tc", 5, 0, 0);

    $display("[TB] runtime max_val drop");
    applyStimulus(0, 0, 1, 1, 10, 15, WRAP, 0);
    tick();
    checkOutput("drop_load_w", 10, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 4, WRAP, 0);
    tick();
    checkOutput("drop_wrap_up", 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 10, 15, SAT, 0);
    tick();
    checkOutput("drop_load_s", 10, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 4, SAT, 0);
    tick();
    checkOutput("drop_sat_down", 4, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 4, SAT, 0);
    tick();
    checkOutput("hold_en0", 4, 0, 0);

    $display("[TB] reserved mode and wrap corners");
    applyStimulus(0, 1, 1, 0, 0, 4, RSVD, 0);
    tick();
    checkOutput("rsvd_wrap", 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 4, WRAP, 0);
    tick();
    checkOutput("wrap_down_0", 4, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 0, WRAP, 0);
    tick();
    checkOutput("max0_a", 0, 1, 0);
    tick();
    checkOutput("max0_b", 0, 1, 0);

    $display("[TB] load with enable");
    applyStimulus(0, 1, 1, 1, 7, 15, WRAP, 0);
    tick();
    checkOutput("load_en", 7, 0, 0);
    applyStimulus(0, 1, 1, 0, 7, 15, WRAP, 0);
    tick();
    checkOutput("after_load", 8, 0, 0);

    $display("[TB] reset mid-count");
    applyStimulus(0, 1, 1, 1, 4, 5, ONESHOT, 2);
    tick();
    checkOutput("pre_load", 4, 0, 0);
    applyStimulus(0, 1, 1, 0, 4, 5, ONESHOT, 2);
    tick();
    checkOutput("pre_p1", 4, 0, 0);
    tick();
    checkOutput("pre_p2", 4, 0, 0);
    tick();
    checkOutput("pre_done", 5, 1, 1);
    tick();
    checkOutput("pre_hold", 5, 0, 1);
    applyStimulus(1, 1, 1, 1, 7, 5, ONESHOT, 2);
    tick();
    checkOutput("rst_mid", 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 5, ONESHOT, 2);
    tick();
    checkOutput("rst_p1", 0, 0, 0);
    tick();
    checkOutput("rst_p2", 0, 0, 0);
    tick();
    checkOutput("rst_step", 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/count_mod_n.md
# count_mod_n

Parametrised programmable up/down counter with a built-in prescaler. It supersedes the fixed free-running up/down counter and adds runtime modulus, synchronous load, and wrap, saturate and one-shot modes. A registered terminal-count pulse and a one-shot done flag let it serve as the shared timer/event counter for the class-report peripherals.

## Interface
- `W`, default 20: counter width.
- `PRE_W`, default 8: prescaler width.
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `en`  in  1: count enable; gates both the prescaler and the count.
- `up`  in  1: direction; 1 counts up, 0 counts down. Sampled on each step.
- `load`  in  1: synchronous load of `load_val`.
- `load_val`  in  W: load value; clamped to `max_val`.
- `max_val`  in  W: modulus; count range is 0..`max_val`.
- `mode`  in  2: 0 WRAP, 1 SAT, 2 ONESHOT, 3 reserved (behaves as WRAP).
- `presc`  in  PRE_W: one step every `presc`+1 enabled cycles.
- `count`  out  W: current count (registered).
- `tc`  out  1: terminal-count pulse (registered).
- `done`  out  1: sticky ONESHOT completion flag (registered).

## Operation
- Priority order: `rst` > `load` > step. With `en`=0 and `load`=0, all state holds.
- Reset:
  - `count`=0, `tc`=0, `done`=0.
  - Prescaler counter p=0.
- Load:
  - `count` = min(`load_val`, `max_val`).
  - p=0, `done`=0, `tc`=0.
  - `en` is ignored in the load cycle.
- Prescaler:
  - When `en`=1 and p==`presc`: p<=0 and a step occurs this cycle.
  - When `en`=1 and p!=`presc`: p<=p+1.
  - When `en`=0: p holds.
  - `presc`=0 gives a step on every enabled cycle.
  - If p>`presc` (after a runtime change), treat it as p==`presc`.
- Step is suppressed when `mode`==ONESHOT and `done`=1. Otherwise the terminal value T is `max_val` when `up`=1 and 0 when `up`=0.
- Up step:
  - `count` < `max_val`: +1.
  - `count` >= `max_val`, WRAP: 0.
  - `count` >= `max_val`, SAT/ONESHOT: `max_val`.
- Down step:
  - `count`==0, WRAP: `max_val`.
  - `count`==0, SAT/ONESHOT: hold at 0.
  - `count` > `max_val`: clamp to `max_val`.
  - Otherwise: -1.
- `tc` is 1 in the cycle after a step whose next count == T **and** whose count before the step != T. The exception is WRAP, where every step producing T pulses, including `max_val`=0.
- Holding at the terminal in SAT/ONESHOT never re-pulses `tc`.
- `done` sets together with the `tc` pulse when `mode`==ONESHOT. It is cleared only by `rst` or `load`. It holds across mode changes.
- Width rule: arithmetic is modulo 2^W internally, but the clamps above guarantee `count` <= `max_val` after any step or load.

## Timing
- Latency from a qualifying `en` edge to the `count` update is 1 clock.
- `tc` and `done` change in the same cycle as `count`.
- `tc` is exactly one cycle wide per event.
- Runtime changes to `max_val`, `mode`, `up` or `presc` take effect on the next step, with no pipeline flush.
- Reset mid-operation: outputs reach reset values on the first rising edge with `rst`=1, regardless of `load` or `en`.
- Load and step in the same cycle: load wins, no step, and p is cleared.

## Structure
- Package `count_pkg`: enum `count_mode_t` {WRAP, SAT, ONESHOT, RSVD}.
- Sub-module `prescaler` (params PRE_W; ports clk, rst, clr, en, presc, strobe) holds p. Its `clr` input is driven by `load`.
- The top module holds the count register, the next-state combinational logic, and the `tc`/`done` registers.

## Test plan
- Reset, then `en`=1, `up`=1, `presc`=0, `max_val`=3, WRAP: count 0,1,2,3,0,1; `tc` high only in the cycles count shows 3.
- SAT, `up`=0, load 2, `presc`=1: count changes every 2nd cycle 2,1,0; one `tc` when 0 is reached; count holds at 0 with no further `tc`.
- ONESHOT, `max_val`=5, from 0 up: `tc` and `done` rise together at count=5; further `en` leaves count=5 and `done`=1. Then `load`=1 with `load_val`=9 gives count=5, `done`=0.
- Runtime `max_val` drop: count=10, set `max_val`=4, WRAP up step gives 0; SAT down step gives 4.
- Simultaneous `load`=1 and `en`=1 with `presc`=0, `load_val`=7: count=7, no `tc`, next enabled cycle gives 8.
- `rst` asserted mid-count with `load`=1: next cycle count=0, `tc`=0, `done`=0. The prescaler restarts, so the first step comes `presc`+1 cycles later.
